branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch predictor and resolution unit for the 5-stage RISC-V pipeline.
- IF side: looks up the fetch PC in a direct-mapped table (2-bit saturating counter plus BTB tag/target per entry) and supplies a predicted next PC.
- EX side: consumes the taken/not-taken result of the EX-stage branch comparator, trains the table, and raises redirect/flush on a misprediction.
- Sits between the comparator output and the PC-select mux / hazard unit.

Parameters:
- ENTRIES, 16: number of table entries; power of two, 4..256.
- INDEX_W, $clog2(ENTRIES): index width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- if_pc  in  32  PC of the instruction in IF.
- pred_taken  out  1  IF prediction: branch taken.
- pred_pc  out  32  predicted next PC: BTB target if pred_taken, else if_pc+4.
- ex_valid  in  1  a conditional branch leaves EX this cycle; hazard unit deasserts it during stalls/bubbles.
- ex_pc  in  32  PC of that branch.
- ex_br_type  in  3  comparator type code; 0 = no branch, 1..6 = beq/blt/bne/bge/bltu/bgeu.
- ex_br  in  1  actual outcome from the comparator.
- ex_target  in  32  computed branch target (pc+imm).
- ex_pred_taken  in  1  pred_taken carried down the pipeline with this instruction.
- ex_pred_pc  in  32  pred_pc carried down the pipeline with this instruction.
- redirect  out  1  misprediction: load redirect_pc into PC and flush IF/ID and ID/EX.
- redirect_pc  out  32  correct next PC.

Behaviour:
- Indexing:
  - idx = pc[INDEX_W+1:2].
  - tag = pc[31:INDEX_W+2].
  - Each entry holds: cnt (2b), valid (1b), tag, target (32b).
- Reset (asynchronous, immediate, including mid-operation):
  - all cnt = 2'b01 (weakly not-taken); all valid = 0.
  - Outputs then evaluate to pred_taken=0, pred_pc=if_pc+4, redirect=0 (given ex_valid=0).
- Prediction (combinational, 0 cycles):
  - hit = valid[idx] && tag match.
  - pred_taken = hit && cnt[idx][1].
  - pred_pc = pred_taken ? target[idx] : if_pc+4.
  - Adds wrap modulo 2^32.
- Resolution (combinational):
  - act = ex_valid && ex_br_type!=0.
  - correct_pc = ex_br ? ex_target : ex_pc+4.
  - redirect = act && (ex_br != ex_pred_taken || (ex_br && ex_pred_pc != ex_target)).
  - redirect_pc = correct_pc whenever act, else 32'b0.
- Update (posedge clk, when act):
  - ex_br=1: cnt = min(cnt+1, 3); valid=1; tag=tag(ex_pc); target=ex_target.
  - ex_br=0: cnt = max(cnt-1, 0); valid/tag/target unchanged.
  - Saturation at 0 and 3 is mandatory; no wrap.
  - On a tag miss, cnt is updated for the existing entry anyway; there is no separate per-tag counter.
- Same-cycle read/write to one index: IF sees the old contents; the new value is visible the following cycle. No bypass.
- act=0 (including ex_br_type=0 with ex_valid=1): no state change, redirect=0.
- Stalls: the block holds no per-instruction state. Each branch is counted only while ex_valid=1, which the hazard unit asserts exactly once per branch.

Optional Feature:
- BP_STATS_EN defined:
  - Adds outputs stat_branches [31:0] and stat_mispredicts [31:0].
  - stat_branches increments on every act; stat_mispredicts increments on every redirect.
  - Both reset to 0 asynchronously and wrap at 2^32.
- BP_STATS_EN undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- After reset, if_pc=0x100 -> pred_taken=0, pred_pc=0x104. Then ex_valid=1, ex_pc=0x100, br_type=1, ex_br=1, ex_target=0x80, ex_pred_taken=0, ex_pred_pc=0x104 -> redirect=1, redirect_pc=0x80. Next cycle, if_pc=0x100 -> pred_taken=1 (cnt 2), pred_pc=0x80.
- Resolve 0x100 as taken 4 times, then not-taken once -> cnt goes 1→2→3→3→3→2; pred_taken stays 1. A second not-taken -> cnt=1, pred_taken=0.
- Predicted taken with ex_pred_pc=0x80 but ex_target=0x90 and ex_br=1 -> redirect=1, redirect_pc=0x90; BTB target becomes 0x90.
- Aliasing with ENTRIES=16: train 0x100 taken, then if_pc=0x140 (same idx, different tag) -> pred_taken=0, pred_pc=0x144.
- ex_valid=1, br_type=0, ex_br=1 -> redirect=0, table unchanged. Assert rst mid-training -> valid cleared at once; if_pc=0x100 predicts not-taken.
- BP_STATS_EN defined: 3 branches including 1 mispredict -> stat_branches=3, stat_mispredicts=1.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Pipeline-facing signal bundle for branch_predictor: the IF lookup and the EX resolution.
// The master side is the pipeline, and the slave side is the predictor.
interface branch_predictor_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [2:0]  ex_br_type;
  logic        ex_br;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_br_type, ex_br, ex_target, ex_pred_taken, ex_pred_pc,
    input  pred_taken, pred_pc, redirect, redirect_pc
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_br_type, ex_br, ex_target, ex_pred_taken, ex_pred_pc,
    output pred_taken, pred_pc, redirect, redirect_pc
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped predictor that uses 2-bit saturating counters and a BTB. It also resolves branches and raises redirects.
// Optional BP_STATS_EN adds the branch and mispredict counters o_stat_branches and o_stat_mispredicts.
module branch_predictor #(
  parameter  int ENTRIES = 16,
  localparam int INDEX_W = $clog2(ENTRIES)
) (
  input logic clk,
  input logic rst,
  branch_predictor_if.slave bp
`ifdef BP_STATS_EN
  ,
  output logic [31:0] o_stat_branches,
  output logic [31:0] o_stat_mispredicts
`endif
);
  localparam int TAG_W = 32 - INDEX_W - 2;

  logic [1:0]         r_cnt    [ENTRIES];
  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];

  logic [INDEX_W-1:0] w_if_idx;
  logic [TAG_W-1:0]   w_if_tag;
  logic [INDEX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0]   w_ex_tag;
  logic               w_hit;
  logic               w_act;
  logic [31:0]        w_correct_pc;

  assign w_if_idx = bp.if_pc[INDEX_W+1:2];
  assign w_if_tag = bp.if_pc[31:INDEX_W+2];
  assign w_ex_idx = bp.ex_pc[INDEX_W+1:2];
  assign w_ex_tag = bp.ex_pc[31:INDEX_W+2];

  // The lookup reads registered state only, so a same-cycle update becomes visible on the next cycle.
  assign w_hit          = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign bp.pred_taken  = w_hit && r_cnt[w_if_idx][1];
  assign bp.pred_pc     = bp.pred_taken ? r_target[w_if_idx] : bp.if_pc + 32'd4;

  assign w_act          = bp.ex_valid && (bp.ex_br_type != 3'd0);
  assign w_correct_pc   = bp.ex_br ? bp.ex_target : bp.ex_pc + 32'd4;
  assign bp.redirect    = w_act && ((bp.ex_br != bp.ex_pred_taken) ||
                                    (bp.ex_br && (bp.ex_pred_pc != bp.ex_target)));
  assign bp.redirect_pc = w_act ? w_correct_pc : 32'd0;

  // The counter is trained even on a tag miss, because each index has only one counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= 2'b01;
      r_valid <= '0;
    end else if (w_act) begin
      if (bp.ex_br) begin
        if (r_cnt[w_ex_idx] != 2'b11) r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] + 2'd1;
        r_valid[w_ex_idx] <= 1'b1;
      end else if (r_cnt[w_ex_idx] != 2'b00) begin
        r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] - 2'd1;
      end
    end
  end

  // Tag and target are only meaningful while valid is set, so they are not reset.
  always_ff @(posedge clk) begin
    if (w_act && bp.ex_br) begin
      r_tag[w_ex_idx]    <= w_ex_tag;
      r_target[w_ex_idx] <= bp.ex_target;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_branches    <= 32'd0;
      r_stat_mispredicts <= 32'd0;
    end else begin
      if (w_act)       r_stat_branches    <= r_stat_branches + 32'd1;
      if (bp.redirect) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign o_stat_branches    = r_stat_branches;
  assign o_stat_mispredicts = r_stat_mispredicts;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard testbench for branch_predictor: directed scenarios followed by randomized traffic.
// The checks compare the DUT against a table-level reference model.
module tb_branch_predictor;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if bp();

`ifdef BP_STATS_EN
  logic [31:0] statBr;
  logic [31:0] statMis;
  branch_predictor #(.ENTRIES(N)) dut (.clk(clk), .rst(rst), .bp(bp),
                                       .o_stat_branches(statBr), .o_stat_mispredicts(statMis));
`else
  branch_predictor #(.ENTRIES(N)) dut (.clk(clk), .rst(rst), .bp(bp));
`endif

  typedef struct {
    logic        pt;
    logic [31:0] ppc;
    logic        rd;
    logic [31:0] rpc;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   checks = 0;
  int   errors = 0;

  // Reference model: one counter, valid bit, tag and target per slot
  int unsigned mCnt[N];
  bit          mValid[N];
  logic [31:0] mTag[N];
  logic [31:0] mTarget[N];
  logic [31:0] mBranches, mMispredicts;
  bit          pendAct, pendBr;
  logic [31:0] pendPc, pendTarget;

  function automatic int slotOf(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic logic [31:0] tagOf(input logic [31:0] pc);
    return pc / (4 * N);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      mCnt[i]   = 1;
      mValid[i] = 0;
    end
    pendAct      = 0;
    mBranches    = 0;
    mMispredicts = 0;
  endtask

  task automatic modelPredict(input logic [31:0] pc, output logic pt, output logic [31:0] ppc);
    int s;
    s   = slotOf(pc);
    pt  = mValid[s] && (mTag[s] == tagOf(pc)) && (mCnt[s] >= 2);
    ppc = pt ? mTarget[s] : pc + 32'd4;
  endtask

  task automatic modelCommit();
    int s;
    if (pendAct) begin
      s = slotOf(pendPc);
      if (pendBr) begin
        mCnt[s]    = (mCnt[s] < 3) ? mCnt[s] + 1 : 3;
        mValid[s]  = 1;
        mTag[s]    = tagOf(pendPc);
        mTarget[s] = pendTarget;
      end else begin
        mCnt[s] = (mCnt[s] > 0) ? mCnt[s] - 1 : 0;
      end
    end
    pendAct = 0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ifPc, input logic exValid, input logic [2:0] brType,
                               input logic br, input logic [31:0] exPc, input logic [31:0] exTarget,
                               input logic exPt, input logic [31:0] exPpc);
    exp_t e;
    bit   act;
    @(posedge clk); #1;
    modelCommit();
    bp.if_pc         = ifPc;
    bp.ex_valid      = exValid;
    bp.ex_br_type    = brType;
    bp.ex_br         = br;
    bp.ex_pc         = exPc;
    bp.ex_target     = exTarget;
    bp.ex_pred_taken = exPt;
    bp.ex_pred_pc    = exPpc;
    act = exValid && (brType != 3'd0);
    modelPredict(ifPc, e.pt, e.ppc);
    e.rd  = act && ((br != exPt) || (br && exPpc != exTarget));
    e.rpc = act ? (br ? exTarget : exPc + 32'd4) : 32'd0;
    expQ.push_back(e);
    pendAct    = act;
    pendBr     = br;
    pendPc     = exPc;
    pendTarget = exTarget;
    if (act)  mBranches    = mBranches + 32'd1;
    if (e.rd) mMispredicts = mMispredicts + 32'd1;
  endtask

  // Resolve a branch at pc, carrying along the prediction the model would have made for it
  task automatic resolve(input logic [31:0] pc, input logic br, input logic [31:0] target);
    logic        pt;
    logic [31:0] ppc;
    modelPredict(pc, pt, ppc);
    applyStimulus(pc, 1'b1, 3'd1, br, pc, target, pt, ppc);
  endtask

  task automatic idle(input logic [31:0] ifPc);
    applyStimulus(ifPc, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  // Raise reset between clock edges and check the outputs while it is held
  task automatic resetMidCycle(input logic [31:0] ifPc);
    exp_t e;
    @(posedge clk); #1;
    rst         = 1'b1;
    bp.ex_valid = 1'b0;
    bp.if_pc    = ifPc;
    modelReset();
    modelPredict(ifPc, e.pt, e.ppc);
    e.rd  = 1'b0;
    e.rpc = 32'd0;
    expQ.push_back(e);
    #6;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      checkOutput("pred_taken", {31'd0, bp.pred_taken}, {31'd0, monE.pt});
      checkOutput("pred_pc", bp.pred_pc, monE.ppc);
      checkOutput("redirect", {31'd0, bp.redirect}, {31'd0, monE.rd});
      checkOutput("redirect_pc", bp.redirect_pc, monE.rpc);
    end
  end

  initial begin
    logic [31:0] pc, tgt, ppc;
    logic        pt;
    rst = 1'b1;
    bp.if_pc = 32'd0; bp.ex_valid = 1'b0; bp.ex_br_type = 3'd0; bp.ex_br = 1'b0;
    bp.ex_pc = 32'd0; bp.ex_target = 32'd0; bp.ex_pred_taken = 1'b0; bp.ex_pred_pc = 32'd0;
    modelReset();

    resetMidCycle(32'h100);
    applyStimulus(32'h100, 1'b1, 3'd1, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
    idle(32'h100);
    repeat (3) resolve(32'h100, 1'b1, 32'h80);
    resolve(32'h100, 1'b0, 32'h80);
    resolve(32'h100, 1'b0, 32'h80);
    idle(32'h100);
    repeat (2) resolve(32'h100, 1'b1, 32'h80);
    applyStimulus(32'h100, 1'b1, 3'd2, 1'b1, 32'h100, 32'h90, 1'b1, 32'h80);
    idle(32'h100);
    idle(32'h140);
    applyStimulus(32'h100, 1'b1, 3'd0, 1'b1, 32'h100, 32'h200, 1'b0, 32'h104);
    idle(32'h100);
    resolve(32'h100, 1'b1, 32'h90);
    resetMidCycle(32'h100);
    idle(32'h100);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        resetMidCycle(32'h100 + ($urandom_range(0, 31) << 2));
      end else begin
        pc  = ($urandom_range(0, 1) ? 32'h100 : 32'h2100) + ($urandom_range(0, 31) << 2);
        tgt = $urandom_range(0, 3) == 0 ? $urandom : 32'h4000 + ($urandom_range(0, 7) << 2);
        modelPredict(pc, pt, ppc);
        if ($urandom_range(0, 4) == 0) begin
          pt  = 1'($urandom);
          ppc = $urandom;
        end
        applyStimulus(($urandom_range(0, 1) ? 32'h100 : 32'h2100) + ($urandom_range(0, 31) << 2),
                      $urandom_range(0, 9) < 7, 3'($urandom_range(0, 6)), 1'($urandom),
                      pc, tgt, pt, ppc);
      end
    end

    resetMidCycle(32'h100);
    resolve(32'h100, 1'b1, 32'h80);
    resolve(32'h100, 1'b1, 32'h80);
    resolve(32'h100, 1'b1, 32'h80);
    idle(32'h100);
    @(posedge clk); #2;
`ifdef BP_STATS_EN
    checkOutput("stat_branches", statBr, mBranches);
    checkOutput("stat_mispredicts", statMis, mMispredicts);
`endif
    @(negedge clk); #1;
    checkOutput("scoreboard_drained", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
